// File: rtl/axi_rr_xbar.sv
// rtl/axi_rr_xbar.sv - round-robin NUM_M x NUM_S AXI-lite interconnect, one transaction in flight
module axi_rr_xbar #(
  parameter int NUM_M = 2,
  parameter int NUM_S = 3,
  parameter logic [NUM_S*32-1:0] SLV_BASE = {32'h0200_0000, 32'h1000_0000, 32'h8000_0000},
  parameter logic [NUM_S*32-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_F000, 32'hF800_0000}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_M*32-1:0]  m_araddr,
  input  logic [NUM_M-1:0]     m_arvalid,
  output logic [NUM_M-1:0]     m_arready,
  output logic [NUM_M*32-1:0]  m_rdata,
  output logic [NUM_M*2-1:0]   m_rresp,
  output logic [NUM_M-1:0]     m_rvalid,
  input  logic [NUM_M-1:0]     m_rready,
  input  logic [NUM_M*32-1:0]  m_awaddr,
  input  logic [NUM_M*32-1:0]  m_wdata,
  input  logic [NUM_M*4-1:0]   m_wstrb,
  input  logic [NUM_M-1:0]     m_wvalid,
  output logic [NUM_M-1:0]     m_wready,
  output logic [NUM_M*2-1:0]   m_bresp,
  output logic [NUM_M-1:0]     m_bvalid,
  input  logic [NUM_M-1:0]     m_bready,
  output logic [NUM_S*32-1:0]  s_araddr,
  output logic [NUM_S-1:0]     s_arvalid,
  input  logic [NUM_S-1:0]     s_arready,
  input  logic [NUM_S*32-1:0]  s_rdata,
  input  logic [NUM_S*2-1:0]   s_rresp,
  input  logic [NUM_S-1:0]     s_rvalid,
  output logic [NUM_S-1:0]     s_rready,
  output logic [NUM_S*32-1:0]  s_awaddr,
  output logic [NUM_S*32-1:0]  s_wdata,
  output logic [NUM_S*4-1:0]   s_wstrb,
  output logic [NUM_S-1:0]     s_wvalid,
  input  logic [NUM_S-1:0]     s_wready,
  input  logic [NUM_S*2-1:0]   s_bresp,
  input  logic [NUM_S-1:0]     s_bvalid,
  output logic [NUM_S-1:0]     s_bready
);
  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP, S_ERR_R, S_ERR_W} state_t;

  state_t          r_state;
  logic [MW-1:0]   r_gnt;
  logic [MW-1:0]   r_ptr;
  logic [SW-1:0]   r_sel;
  logic [31:0]     r_addr;
  logic            r_err_ph;

  logic [NUM_M-1:0] w_req;
  logic [MW-1:0]    w_gnt;
  logic             w_found;
  logic             w_is_rd;
  logic [31:0]      w_gaddr;
  logic [SW-1:0]    w_dsel;
  logic             w_hit;
  logic [MW-1:0]    w_ptr_nxt;

  assign w_req     = m_arvalid | m_wvalid;
  assign w_ptr_nxt = (int'(r_gnt) == NUM_M - 1) ? '0 : r_gnt + 1'b1;

  // Two passes: first requester at/after the pointer, else wrap to the lowest requester.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && w_req[i] && (i >= int'(r_ptr))) begin
        w_gnt   = MW'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && w_req[i]) begin
        w_gnt   = MW'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_is_rd = m_arvalid[w_gnt];
  assign w_gaddr = w_is_rd ? m_araddr[32*w_gnt +: 32] : m_awaddr[32*w_gnt +: 32];

  // Descending scan so the lowest-index matching slave is the one left standing.
  always_comb begin
    w_hit  = 1'b0;
    w_dsel = '0;
    for (int j = NUM_S - 1; j >= 0; j--) begin
      if ((w_gaddr & SLV_MASK[32*j +: 32]) == SLV_BASE[32*j +: 32]) begin
        w_hit  = 1'b1;
        w_dsel = SW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_ptr    <= '0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_err_ph <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_gnt    <= w_gnt;
          r_sel    <= w_dsel;
          r_addr   <= w_gaddr;
          r_err_ph <= 1'b0;
          if (w_hit) r_state <= w_is_rd ? S_RADDR : S_WREQ;
          else       r_state <= w_is_rd ? S_ERR_R : S_ERR_W;
        end
        S_RADDR: if (s_arready[r_sel]) r_state <= S_RDATA;
        S_RDATA: if (s_rvalid[r_sel] && m_rready[r_gnt]) begin
          r_state <= S_IDLE;
          r_ptr   <= w_ptr_nxt;
        end
        S_WREQ:  if (s_wready[r_sel]) r_state <= S_WRESP;
        S_WRESP: if (s_bvalid[r_sel] && m_bready[r_gnt]) begin
          r_state <= S_IDLE;
          r_ptr   <= w_ptr_nxt;
        end
        S_ERR_R: if (!r_err_ph) r_err_ph <= 1'b1;
                 else if (m_rready[r_gnt]) begin
                   r_state <= S_IDLE;
                   r_ptr   <= w_ptr_nxt;
                 end
        S_ERR_W: if (!r_err_ph) r_err_ph <= 1'b1;
                 else if (m_bready[r_gnt]) begin
                   r_state <= S_IDLE;
                   r_ptr   <= w_ptr_nxt;
                 end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Routing is a pure function of state, so reset silences every output at once.
  always_comb begin
    m_arready = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rvalid  = '0;
    m_wready  = '0;
    m_bresp   = '0;
    m_bvalid  = '0;
    s_araddr  = '0;
    s_arvalid = '0;
    s_rready  = '0;
    s_awaddr  = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    case (r_state)
      S_RADDR: begin
        s_arvalid[r_sel]          = 1'b1;
        s_araddr[32*r_sel +: 32]  = r_addr;
        m_arready[r_gnt]          = s_arready[r_sel];
      end
      S_RDATA: begin
        m_rvalid[r_gnt]           = s_rvalid[r_sel];
        m_rdata[32*r_gnt +: 32]   = s_rdata[32*r_sel +: 32];
        m_rresp[2*r_gnt +: 2]     = s_rresp[2*r_sel +: 2];
        s_rready[r_sel]           = m_rready[r_gnt];
      end
      S_WREQ: begin
        s_wvalid[r_sel]           = 1'b1;
        s_awaddr[32*r_sel +: 32]  = m_awaddr[32*r_gnt +: 32];
        s_wdata[32*r_sel +: 32]   = m_wdata[32*r_gnt +: 32];
        s_wstrb[4*r_sel +: 4]     = m_wstrb[4*r_gnt +: 4];
        m_wready[r_gnt]           = s_wready[r_sel];
      end
      S_WRESP: begin
        m_bvalid[r_gnt]           = s_bvalid[r_sel];
        m_bresp[2*r_gnt +: 2]     = s_bresp[2*r_sel +: 2];
        s_bready[r_sel]           = m_bready[r_gnt];
      end
      S_ERR_R: begin
        m_arready[r_gnt]          = !r_err_ph;
        m_rvalid[r_gnt]           = r_err_ph;
        m_rresp[2*r_gnt +: 2]     = r_err_ph ? 2'b11 : 2'b00;
      end
      S_ERR_W: begin
        m_wready[r_gnt]           = !r_err_ph;
        m_bvalid[r_gnt]           = r_err_ph;
        m_bresp[2*r_gnt +: 2]     = r_err_ph ? 2'b11 : 2'b00;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_rr_xbar.sv
// tb/tb_axi_rr_xbar.sv - directed table-driven bench for axi_rr_xbar (2 masters, 3 slaves)
module tb_axi_rr_xbar;
  localparam int NM = 2;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM*32-1:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [NM-1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NM*2-1:0]  m_rresp, m_bresp;
  logic [NM*4-1:0]  m_wstrb;
  logic [NS*32-1:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [NS-1:0]    s_arvalid, s_arready, s_rvalid, s_rready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [NS*2-1:0]  s_rresp, s_bresp;
  logic [NS*4-1:0]  s_wstrb;

  axi_rr_xbar #(.NUM_M(NM), .NUM_S(NS)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          s;
    logic [1:0]  resp;
    int          sa;
    int          sr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, input int s, input logic [31:0] rd,
                         input logic [1:0] rsp, input int sa, input int sr);
    int n;
    logic [NM-1:0] mo;
    logic [NS-1:0] so;
    logic leak;
    mo = '0; mo[m] = 1'b1;
    so = '0;
    leak = 1'b0;
    m_araddr[32*m +: 32] = addr;
    m_arvalid[m] = 1'b1;
    m_rready[m]  = 1'b0;
    #1;
    if (s >= 0) begin
      so[s] = 1'b1;
      n = 0;
      while (s_arvalid == '0 && n < 10) begin tick(); n++; end
      chk("ar_sel", s_arvalid, so);
      chk("ar_addr", s_araddr[32*s +: 32], addr);
      chk("ar_no_w", s_wvalid, 0);
      repeat (sa) begin chk("ar_wait", m_arready, 0); tick(); end
      s_arready[s] = 1'b1;
      #1 chk("arready", m_arready, mo);
      tick();
      s_arready[s] = 1'b0;
      m_arvalid[m] = 1'b0;
      s_rdata[32*s +: 32] = rd;
      s_rresp[2*s +: 2]   = rsp;
      s_rvalid[s] = 1'b1;
      #1;
      chk("rvalid", m_rvalid, mo);
      chk("rdata", m_rdata[32*m +: 32], rd);
      chk("rresp", m_rresp[2*m +: 2], rsp);
      repeat (sr) begin chk("r_stall", s_rready, 0); tick(); chk("r_hold", m_rvalid, mo); end
      m_rready[m] = 1'b1;
      #1 chk("rready", s_rready, so);
      tick();
      #1 chk("r_once", m_rvalid, 0);
      s_rvalid[s] = 1'b0;
      m_rready[m] = 1'b0;
    end else begin
      n = 0;
      while (m_arready[m] == 1'b0 && n < 10) begin leak |= (|s_arvalid) | (|s_wvalid); tick(); n++; end
      chk("err_arready", m_arready, mo);
      tick();
      m_arvalid[m] = 1'b0;
      #1;
      chk("err_arpulse", m_arready, 0);
      chk("err_rvalid", m_rvalid, mo);
      chk("err_rresp", m_rresp[2*m +: 2], 2'b11);
      chk("err_rdata", m_rdata[32*m +: 32], 0);
      repeat (sr) begin leak |= (|s_arvalid) | (|s_wvalid); tick(); chk("err_rhold", m_rvalid, mo); end
      m_rready[m] = 1'b1;
      tick();
      #1 chk("err_r_once", m_rvalid, 0);
      m_rready[m] = 1'b0;
      chk("err_r_no_slave", leak, 0);
    end
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                          input int s, input logic [1:0] rsp, input int sa, input int sr);
    int n;
    logic [NM-1:0] mo;
    logic [NS-1:0] so;
    logic leak;
    mo = '0; mo[m] = 1'b1;
    so = '0;
    leak = 1'b0;
    m_awaddr[32*m +: 32] = addr;
    m_wdata[32*m +: 32]  = wd;
    m_wstrb[4*m +: 4]    = st;
    m_wvalid[m] = 1'b1;
    m_bready[m] = 1'b0;
    #1;
    if (s >= 0) begin
      so[s] = 1'b1;
      n = 0;
      while (s_wvalid == '0 && n < 10) begin tick(); n++; end
      chk("w_sel", s_wvalid, so);
      chk("w_addr", s_awaddr[32*s +: 32], addr);
      chk("w_data", s_wdata[32*s +: 32], wd);
      chk("w_strb", s_wstrb[4*s +: 4], st);
      chk("w_no_ar", s_arvalid, 0);
      repeat (sa) begin chk("w_wait", m_wready, 0); tick(); end
      s_wready[s] = 1'b1;
      #1 chk("wready", m_wready, mo);
      tick();
      s_wready[s] = 1'b0;
      m_wvalid[m] = 1'b0;
      s_bresp[2*s +: 2] = rsp;
      s_bvalid[s] = 1'b1;
      #1;
      chk("bvalid", m_bvalid, mo);
      chk("bresp", m_bresp[2*m +: 2], rsp);
      repeat (sr) begin chk("b_stall", s_bready, 0); tick(); chk("b_hold", m_bvalid, mo); end
      m_bready[m] = 1'b1;
      #1 chk("bready", s_bready, so);
      tick();
      #1 chk("b_once", m_bvalid, 0);
      s_bvalid[s] = 1'b0;
      m_bready[m] = 1'b0;
    end else begin
      n = 0;
      while (m_wready[m] == 1'b0 && n < 10) begin leak |= (|s_arvalid) | (|s_wvalid); tick(); n++; end
      chk("err_wready", m_wready, mo);
      tick();
      m_wvalid[m] = 1'b0;
      #1;
      chk("err_wpulse", m_wready, 0);
      chk("err_bvalid", m_bvalid, mo);
      chk("err_bresp", m_bresp[2*m +: 2], 2'b11);
      repeat (sr) begin leak |= (|s_arvalid) | (|s_wvalid); tick(); chk("err_bhold", m_bvalid, mo); end
      m_bready[m] = 1'b1;
      tick();
      #1 chk("err_b_once", m_bvalid, 0);
      m_bready[m] = 1'b0;
      chk("err_w_no_slave", leak, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NM-1:0] mo;
    tbl[0] = '{0, 1'b0, 32'h8000_0010, 32'h1111_0000, 4'h0, 0, 2'b00, 0, 0};
    tbl[1] = '{1, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 4'b0011, 1, 2'b00, 1, 1};
    tbl[2] = '{1, 1'b0, 32'h0200_1234, 32'hA5A5_5A5A, 4'h0, 2, 2'b01, 0, 0};
    tbl[3] = '{0, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b1111, 0, 2'b10, 0, 0};
    tbl[4] = '{0, 1'b0, 32'h4000_0000, 32'h0, 4'h0, -1, 2'b11, 0, 2};
    tbl[5] = '{1, 1'b1, 32'h0300_0000, 32'h7777_7777, 4'b0101, -1, 2'b11, 0, 1};
    tbl[6] = '{0, 1'b0, 32'h1000_1000, 32'h0, 4'h0, -1, 2'b11, 0, 0};
    tbl[7] = '{1, 1'b0, 32'h87FF_FFFC, 32'hCAFE_F00D, 4'h0, 0, 2'b00, 0, 0};
    tbl[8] = '{0, 1'b1, 32'h0200_FFFC, 32'h0BAD_F00D, 4'b1000, 2, 2'b00, 0, 0};
    tbl[9] = '{1, 1'b0, 32'h8000_0040, 32'h5555_AAAA, 4'h0, 0, 2'b00, 5, 3};

    m_araddr = '0; m_arvalid = '0; m_rready = '0; m_awaddr = '0; m_wdata = '0;
    m_wstrb = '0; m_wvalid = '0; m_bready = '0;
    s_arready = '0; s_rdata = '0; s_rresp = '0; s_rvalid = '0;
    s_wready = '0; s_bresp = '0; s_bvalid = '0;

    // Reset held with both masters requesting: nothing may be granted or driven.
    rst = 1'b0;
    m_araddr = {32'h8000_0010, 32'h8000_0010};
    m_arvalid = 2'b11;
    m_rready = 2'b11;
    s_arready = '1;
    tick(); tick();
    chk("rst_m", {m_arready, m_rvalid, m_wready, m_bvalid, m_rresp, m_bresp}, 0);
    chk("rst_s", {s_arvalid, s_rready, s_wvalid, s_bready}, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_araddr", s_araddr[31:0], 0);
    s_arready = '0;
    rst = 1'b1;

    // Continuous contention: grants alternate 0,1,0,1 from a reset pointer.
    for (int k = 0; k < 4; k++) begin
      mo = '0; mo[k % 2] = 1'b1;
      n = 0;
      #1;
      while (s_arvalid == '0 && n < 10) begin tick(); n++; end
      chk("rr_ar_sel", s_arvalid, 3'b001);
      s_arready[0] = 1'b1;
      #1 chk("rr_grant", m_arready, mo);
      tick();
      s_arready[0] = 1'b0;
      s_rdata[31:0] = 32'h100 + k;
      s_rresp[1:0]  = 2'b00;
      s_rvalid[0] = 1'b1;
      #1;
      chk("rr_rvalid", m_rvalid, mo);
      chk("rr_rdata", m_rdata[32*(k % 2) +: 32], 32'h100 + k);
      chk("rr_rresp", m_rresp, 0);
      tick();
      s_rvalid[0] = 1'b0;
    end
    m_arvalid = '0;
    m_rready = '0;

    // Master 0 read+write together with master 1 pending: read0, read1, then write0.
    m_araddr[63:32] = 32'h8000_0030;
    m_arvalid[1] = 1'b1;
    m_awaddr[31:0] = 32'h1000_0004;
    m_wdata[31:0]  = 32'h0F0F_0F0F;
    m_wstrb[3:0]   = 4'b1111;
    m_wvalid[0] = 1'b1;
    do_read(0, 32'h8000_0020, 0, 32'h2222_2222, 2'b00, 0, 0);
    do_read(1, 32'h8000_0030, 0, 32'h3333_3333, 2'b00, 0, 0);
    do_write(0, 32'h1000_0004, 32'h0F0F_0F0F, 4'b1111, 1, 2'b00, 0, 0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].s, tbl[i].resp, tbl[i].sa, tbl[i].sr);
      else
        do_read(tbl[i].m, tbl[i].addr, tbl[i].s, tbl[i].data, tbl[i].resp, tbl[i].sa, tbl[i].sr);
    end

    // Leave the pointer at 1, then reset during master 1's RDATA phase.
    do_read(0, 32'h8000_0044, 0, 32'h4444_4444, 2'b00, 0, 0);
    m_araddr[63:32] = 32'h8000_0050;
    m_arvalid[1] = 1'b1;
    n = 0;
    #1;
    while (s_arvalid == '0 && n < 10) begin tick(); n++; end
    s_arready[0] = 1'b1;
    tick();
    s_arready[0] = 1'b0;
    m_arvalid[1] = 1'b0;
    s_rdata[31:0] = 32'hFFFF_FFFF;
    s_rvalid[0] = 1'b1;
    m_rready = 2'b11;
    #1 chk("pre_rst_rvalid", m_rvalid, 2'b10);
    rst = 1'b0;
    #1;
    chk("midrst_m", {m_arready, m_rvalid, m_wready, m_bvalid, m_rresp, m_bresp}, 0);
    chk("midrst_s", {s_arvalid, s_rready, s_wvalid, s_bready}, 0);
    chk("midrst_rdata", m_rdata, 0);
    rst = 1'b1;
    s_rvalid = '0;
    m_rready = '0;
    tick();
    #1 chk("post_rst_idle", {m_arready, m_rvalid, s_arvalid, s_rready}, 0);
    m_araddr = {32'h8000_0060, 32'h8000_0060};
    m_arvalid = 2'b11;
    n = 0;
    #1;
    while (s_arvalid == '0 && n < 10) begin tick(); n++; end
    s_arready[0] = 1'b1;
    #1 chk("post_rst_grant", m_arready, 2'b01);
    tick();
    s_arready[0] = 1'b0;
    m_arvalid = '0;
    m_rready = 2'b11;
    s_rvalid[0] = 1'b1;
    tick();
    s_rvalid = '0;
    m_rready = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
